// File: rtl/am2900_next_addr_ctl.sv
// Next-address control for cascaded Am2909 slices: decodes the microinstruction
// next-address field and tracks the loop counter and sequencer stack depth.
module am2900_next_addr_ctl #(
  parameter int W           = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic         CP,
  input  logic         RST,
  input  logic [3:0]   I,
  input  logic         CCEN_n,
  input  logic         CC_n,
  input  logic [W-1:0] D,
  output logic [1:0]   S,
  output logic         FE_n,
  output logic         PUP,
  output logic         ZERO_n,
  output logic         PL_n,
  output logic         MAP_n,
  output logic         VECT_n,
  output logic         CTR_ZERO,
  output logic         STK_FULL,
  output logic         STK_EMPTY,
  output logic         ERR
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  localparam logic [1:0] S_UPC = 2'b00;
  localparam logic [1:0] S_AR  = 2'b01;
  localparam logic [1:0] S_STK = 2'b10;
  localparam logic [1:0] S_D   = 2'b11;

  logic [W-1:0]  ctr_p0;
  logic [DW-1:0] depth_p0;
  logic          err_p0;

  logic       pass, ctr_nz;
  logic       push, pop, ld, dec, clr;
  logic [1:0] s_d;
  logic       zero_n_d, pl_n_d, map_n_d, vect_n_d;

  assign pass      = CCEN_n | ~CC_n;
  assign ctr_nz    = (ctr_p0 != '0);
  assign CTR_ZERO  = ~ctr_nz;
  assign STK_FULL  = (depth_p0 == DEPTH_MAX);
  assign STK_EMPTY = (depth_p0 == '0);
  assign ERR       = err_p0;

  always_comb begin
    s_d      = S_UPC;
    zero_n_d = 1'b1;
    pl_n_d   = 1'b0;
    map_n_d  = 1'b1;
    vect_n_d = 1'b1;
    push     = 1'b0;
    pop      = 1'b0;
    ld       = 1'b0;
    dec      = 1'b0;
    clr      = 1'b0;
    case (I)
      4'h0: begin zero_n_d = 1'b0; clr = 1'b1; end
      4'h1: if (pass) begin s_d = S_D; push = 1'b1; end
      4'h2: begin s_d = S_D; pl_n_d = 1'b1; map_n_d = 1'b0; end
      4'h3: if (pass) s_d = S_D;
      4'h4: begin push = 1'b1; ld = pass; end
      4'h5: begin push = 1'b1; s_d = pass ? S_D : S_AR; end
      4'h6: begin
        pl_n_d   = 1'b1;
        vect_n_d = 1'b0;
        if (pass) s_d = S_D;
      end
      4'h7: s_d = pass ? S_D : S_AR;
      4'h8: if (ctr_nz) begin s_d = S_STK; dec = 1'b1; end
            else pop = 1'b1;
      4'h9: if (ctr_nz) begin s_d = S_D; dec = 1'b1; end
      4'hA: if (pass) begin s_d = S_STK; pop = 1'b1; end
      4'hB: if (pass) begin s_d = S_D; pop = 1'b1; end
      4'hC: ld = 1'b1;
      4'hD: if (pass) pop = 1'b1;
            else s_d = S_STK;
      4'hE: ;
      4'hF: begin
        // Twin-way branch: stack on pass, else loop on stack until counter drains
        if (pass)        begin s_d = S_STK; pop = 1'b1; end
        else if (ctr_nz) begin s_d = S_STK; dec = 1'b1; end
        else             begin s_d = S_D;   pop = 1'b1; end
      end
      default: ;
    endcase
  end

  // Reset overrides the decode so the sequencer emits address 0
  always_comb begin
    if (RST) begin
      S      = S_UPC;
      FE_n   = 1'b1;
      PUP    = 1'b0;
      ZERO_n = 1'b0;
      PL_n   = 1'b0;
      MAP_n  = 1'b1;
      VECT_n = 1'b1;
    end else begin
      S      = s_d;
      FE_n   = ~(push | pop);
      PUP    = push;
      ZERO_n = zero_n_d;
      PL_n   = pl_n_d;
      MAP_n  = map_n_d;
      VECT_n = vect_n_d;
    end
  end

  // Stage p0: counter, depth and sticky error state
  always_ff @(posedge CP) begin
    if (RST) begin
      ctr_p0   <= '0;
      depth_p0 <= '0;
      err_p0   <= 1'b0;
    end else begin
      if (ld)       ctr_p0 <= D;
      else if (dec) ctr_p0 <= ctr_p0 - W'(1);

      if (clr) begin
        depth_p0 <= '0;
        err_p0   <= 1'b0;
      end else if (push) begin
        if (STK_FULL) err_p0   <= 1'b1;
        else          depth_p0 <= depth_p0 + DW'(1);
      end else if (pop) begin
        if (STK_EMPTY) err_p0   <= 1'b1;
        else           depth_p0 <= depth_p0 - DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_am2900_next_addr_ctl.sv
// Bench for am2900_next_addr_ctl: action-table model checked every cycle,
// plus directed vectors with literal expectations.
module tb_am2900_next_addr_ctl;
  localparam int W  = 12;
  localparam int SD = 4;

  logic         CP = 1'b0;
  logic         RST, CCEN_n, CC_n;
  logic [3:0]   I;
  logic [W-1:0] D;
  logic [1:0]   S;
  logic         FE_n, PUP, ZERO_n, PL_n, MAP_n, VECT_n;
  logic         CTR_ZERO, STK_FULL, STK_EMPTY, ERR;

  int checks = 0;
  int errors = 0;

  am2900_next_addr_ctl #(.W(W), .STACK_DEPTH(SD)) dut (
    .CP(CP), .RST(RST), .I(I), .CCEN_n(CCEN_n), .CC_n(CC_n), .D(D),
    .S(S), .FE_n(FE_n), .PUP(PUP), .ZERO_n(ZERO_n), .PL_n(PL_n),
    .MAP_n(MAP_n), .VECT_n(VECT_n), .CTR_ZERO(CTR_ZERO),
    .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY), .ERR(ERR)
  );

  always #5 CP = ~CP;

  // What one instruction does to the sequencer and the bookkeeping
  typedef struct packed {
    logic [1:0] src;
    bit push, pop, load, decr, clear;
    bit use_pl, use_map, use_vect, force_zero;
  } act_t;

  int m_ctr, m_depth;
  bit m_err, m_valid = 0;

  function automatic act_t action(input logic [3:0] op, input bit p, input bit cz);
    act_t a = '0;
    a.use_pl = 1;
    case (op)
      0: begin a.force_zero = 1; a.clear = 1; end
      1: if (p) begin a.src = 3; a.push = 1; end
      2: begin a.src = 3; a.use_pl = 0; a.use_map = 1; end
      3: if (p) a.src = 3;
      4: begin a.push = 1; a.load = p; end
      5: begin a.push = 1; a.src = p ? 2'd3 : 2'd1; end
      6: begin a.use_pl = 0; a.use_vect = 1; if (p) a.src = 3; end
      7: a.src = p ? 2'd3 : 2'd1;
      8: if (!cz) begin a.src = 2; a.decr = 1; end else a.pop = 1;
      9: if (!cz) begin a.src = 3; a.decr = 1; end
      10: if (p) begin a.src = 2; a.pop = 1; end
      11: if (p) begin a.src = 3; a.pop = 1; end
      12: a.load = 1;
      13: if (p) a.pop = 1; else a.src = 2;
      14: ;
      15: if (p) begin a.src = 2; a.pop = 1; end
          else if (!cz) begin a.src = 2; a.decr = 1; end
          else begin a.src = 3; a.pop = 1; end
      default: ;
    endcase
    return a;
  endfunction

  function automatic bit cur_pass();
    return CCEN_n || !CC_n;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state update
  always @(posedge CP) begin
    act_t a;
    if (RST) begin
      m_ctr = 0; m_depth = 0; m_err = 0; m_valid = 1;
    end else if (m_valid) begin
      a = action(I, cur_pass(), m_ctr == 0);
      if (a.load) m_ctr = int'(D);
      else if (a.decr) m_ctr = m_ctr - 1;
      if (a.clear) begin m_depth = 0; m_err = 0; end
      if (a.push) begin if (m_depth == SD) m_err = 1; else m_depth++; end
      if (a.pop) begin if (m_depth == 0) m_err = 1; else m_depth--; end
    end
  end

  // Full-output compare every cycle once the model is anchored by reset
  always @(negedge CP) begin
    act_t a;
    if (m_valid) begin
      a = action(I, cur_pass(), m_ctr == 0);
      if (RST) begin
        chk("m_S", 16'(S), 0);  chk("m_FE_n", 16'(FE_n), 1);
        chk("m_ZERO_n", 16'(ZERO_n), 0); chk("m_PL_n", 16'(PL_n), 0);
        chk("m_MAP_n", 16'(MAP_n), 1);   chk("m_VECT_n", 16'(VECT_n), 1);
      end else begin
        chk("m_S", 16'(S), 16'(a.src));
        chk("m_FE_n", 16'(FE_n), 16'(!(a.push || a.pop)));
        chk("m_PUP", 16'(PUP), 16'(a.push));
        chk("m_ZERO_n", 16'(ZERO_n), 16'(!a.force_zero));
        chk("m_PL_n", 16'(PL_n), 16'(!a.use_pl));
        chk("m_MAP_n", 16'(MAP_n), 16'(!a.use_map));
        chk("m_VECT_n", 16'(VECT_n), 16'(!a.use_vect));
      end
      chk("m_CTR_ZERO", 16'(CTR_ZERO), 16'(m_ctr == 0));
      chk("m_STK_FULL", 16'(STK_FULL), 16'(m_depth == SD));
      chk("m_STK_EMPTY", 16'(STK_EMPTY), 16'(m_depth == 0));
      chk("m_ERR", 16'(ERR), 16'(m_err));
    end
  end

  task automatic drive(input bit rst, input logic [3:0] op, input bit ccen,
                       input bit cc, input logic [W-1:0] d);
    @(posedge CP); #1;
    RST = rst; I = op; CCEN_n = ccen; CC_n = cc; D = d;
    #2;
  endtask

  initial begin
    RST = 1; I = 4'h1; CCEN_n = 0; CC_n = 0; D = '0;
    // Reset held two edges with a CJS pending
    drive(1, 4'h1, 0, 0, 0);
    chk("rst_ZERO_n", 16'(ZERO_n), 0); chk("rst_FE_n", 16'(FE_n), 1);
    chk("rst_CTR_ZERO", 16'(CTR_ZERO), 1); chk("rst_EMPTY", 16'(STK_EMPTY), 1);
    chk("rst_ERR", 16'(ERR), 0);
    drive(0, 4'hE, 1, 1, 0);
    chk("cont_S", 16'(S), 0); chk("cont_ZERO_n", 16'(ZERO_n), 1);

    // LDCT 3 then RPCT x4
    drive(0, 4'hC, 1, 1, 3);
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'h9, 1, 1, 0);
      chk("rpct_S", 16'(S), 3); chk("rpct_CTR_ZERO", 16'(CTR_ZERO), 0);
    end
    drive(0, 4'h9, 1, 1, 0);
    chk("rpct_end_S", 16'(S), 0); chk("rpct_end_CTR_ZERO", 16'(CTR_ZERO), 1);

    // CJS pass, CRTN fail, CRTN pass
    drive(0, 4'h1, 0, 0, 0);
    chk("cjs_S", 16'(S), 3); chk("cjs_FE_n", 16'(FE_n), 0); chk("cjs_PUP", 16'(PUP), 1);
    drive(0, 4'hA, 0, 1, 0);
    chk("crtn_f_S", 16'(S), 0); chk("crtn_f_FE_n", 16'(FE_n), 1);
    chk("crtn_f_EMPTY", 16'(STK_EMPTY), 0);
    drive(0, 4'hA, 0, 0, 0);
    chk("crtn_p_S", 16'(S), 2); chk("crtn_p_PUP", 16'(PUP), 0); chk("crtn_p_FE_n", 16'(FE_n), 0);
    drive(0, 4'hE, 1, 1, 0);
    chk("crtn_EMPTY", 16'(STK_EMPTY), 1);

    // Overflow, JZ clear, underflow
    for (int k = 0; k < 5; k++) begin
      drive(0, 4'h4, 1, 1, 5);
      if (k == 4) begin
        chk("ovf_FULL", 16'(STK_FULL), 1); chk("ovf_ERR_pre", 16'(ERR), 0);
        chk("ovf_FE_n", 16'(FE_n), 0);
      end
    end
    drive(0, 4'hE, 1, 1, 0);
    chk("ovf_ERR", 16'(ERR), 1); chk("ovf_FULL_hold", 16'(STK_FULL), 1);
    chk("push_ld_CTR_ZERO", 16'(CTR_ZERO), 0);
    drive(0, 4'h0, 1, 1, 0);
    chk("jz_ZERO_n", 16'(ZERO_n), 0);
    drive(0, 4'hB, 1, 1, 0);
    chk("jz_EMPTY", 16'(STK_EMPTY), 1); chk("jz_ERR", 16'(ERR), 0);
    chk("cjpp_S", 16'(S), 3); chk("cjpp_FE_n", 16'(FE_n), 0);
    drive(0, 4'hE, 1, 1, 0);
    chk("unf_ERR", 16'(ERR), 1); chk("unf_EMPTY", 16'(STK_EMPTY), 1);

    // TWB after PUSH with load 2
    drive(0, 4'h0, 1, 1, 0);
    drive(0, 4'h4, 0, 0, 2);
    for (int k = 0; k < 2; k++) begin
      drive(0, 4'hF, 0, 1, 0);
      chk("twb_S", 16'(S), 2); chk("twb_FE_n", 16'(FE_n), 1);
    end
    drive(0, 4'hF, 0, 1, 0);
    chk("twb_end_S", 16'(S), 3); chk("twb_end_FE_n", 16'(FE_n), 0);
    chk("twb_end_PUP", 16'(PUP), 0); chk("twb_end_CTR_ZERO", 16'(CTR_ZERO), 1);
    drive(0, 4'hE, 1, 1, 0);
    chk("twb_EMPTY", 16'(STK_EMPTY), 1); chk("twb_ERR", 16'(ERR), 0);

    // JMAP and CJV fail
    drive(0, 4'h2, 1, 1, 0);
    chk("jmap_S", 16'(S), 3); chk("jmap_MAP_n", 16'(MAP_n), 0); chk("jmap_PL_n", 16'(PL_n), 1);
    drive(0, 4'h6, 0, 1, 0);
    chk("cjv_S", 16'(S), 0); chk("cjv_VECT_n", 16'(VECT_n), 0); chk("cjv_PL_n", 16'(PL_n), 1);

    // Reset mid-operation drops a push-with-load
    drive(0, 4'h1, 0, 0, 0);
    drive(1, 4'h4, 1, 1, 7);
    chk("mid_rst_FE_n", 16'(FE_n), 1); chk("mid_rst_ZERO_n", 16'(ZERO_n), 0);
    drive(0, 4'hE, 1, 1, 0);
    chk("mid_rst_EMPTY", 16'(STK_EMPTY), 1); chk("mid_rst_CTR_ZERO", 16'(CTR_ZERO), 1);

    // Random sweep, checked by the model
    for (int k = 0; k < 300; k++)
      drive(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            W'($urandom_range(0, 4)));

    @(posedge CP); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/am2900_next_addr_ctl.md
Name: am2900_next_addr_ctl

Overview:
- Next-address control unit sitting directly upstream of the cascaded Am2909 sequencer slices.
- Decodes a 4-bit microinstruction next-address field plus a condition code, and drives the sequencer's S, FE, PUP and ZERO lines.
- Drives the three address-source enables: pipeline, map and vector.
- Contains the loop counter and a stack-depth tracker that mirrors the Am2909 4-word file.

Parameters:
W, 12, width of loop counter and of D (three cascaded 4-bit slices)
STACK_DEPTH, 4, depth of the sequencer register file being tracked

Ports:
CP  input  1  common clock, rising edge
RST  input  1  synchronous reset, active-high
I  input  4  next-address instruction
CCEN_n  input  1  condition enable, low = test CC_n
CC_n  input  1  condition, low = true
D  input  W  counter load value (pipeline branch field)
S  output  2  sequencer source select: 00 uPC, 01 AR, 10 stack, 11 D
FE_n  output  1  file enable to sequencer, low = push/pop
PUP  output  1  1 = push, 0 = pop
ZERO_n  output  1  low forces sequencer Y to 0
PL_n  output  1  pipeline branch field drives D bus, active-low
MAP_n  output  1  mapping PROM drives D bus, active-low
VECT_n  output  1  vector source drives D bus, active-low
CTR_ZERO  output  1  loop counter == 0
STK_FULL  output  1  depth == STACK_DEPTH
STK_EMPTY  output  1  depth == 0
ERR  output  1  sticky stack overflow/underflow

Behaviour:
- PASS = CCEN_n | ~CC_n.
- All control outputs are combinational from I, PASS and the registered counter/depth.
- Counter, depth and ERR update on posedge CP.
- Defaults unless overridden below:
  - S=00, FE_n=1, PUP=0, ZERO_n=1.
  - PL_n=0, MAP_n=1, VECT_n=1.
  - Counter holds.
- "push" means FE_n=0, PUP=1, depth+1. "pop" means FE_n=0, PUP=0, depth-1.
- Instructions:
  - 0 JZ: ZERO_n=0; depth <- 0; ERR <- 0.
  - 1 CJS: PASS: S=11, push.
  - 2 JMAP: S=11, PL_n=1, MAP_n=0.
  - 3 CJP: PASS: S=11.
  - 4 PUSH: push; PASS: counter <- D.
  - 5 JSRP: push; S = PASS ? 11 : 01.
  - 6 CJV: PL_n=1, VECT_n=0; PASS: S=11.
  - 7 JRP: S = PASS ? 11 : 01.
  - 8 RFCT: counter≠0: S=10, decrement; counter=0: pop.
  - 9 RPCT: counter≠0: S=11, decrement.
  - A CRTN: PASS: S=10, pop.
  - B CJPP: PASS: S=11, pop.
  - C LDCT: counter <- D.
  - D LOOP: PASS: pop; fail: S=10.
  - E CONT: defaults.
  - F TWB: PASS: S=10, pop; fail with counter≠0: S=10, decrement; fail with counter=0: S=11, pop.
- Conditions listed as PASS/fail only: in the unlisted case, outputs take the defaults.
- Counter:
  - W-bit; decrement never occurs at 0, so there is no wrap.
  - Load has priority over decrement; the two never coincide by decode.
- Stack tracking:
  - Push when STK_FULL: FE_n/PUP still driven (the sequencer overwrites), depth stays STACK_DEPTH, ERR <- 1.
  - Pop when STK_EMPTY: FE_n/PUP still driven, depth stays 0, ERR <- 1.
  - ERR is sticky until RST or JZ.
- Reset (RST high at posedge CP): counter=0, depth=0, ERR=0.
- While RST is high, outputs are forced regardless of I: ZERO_n=0, S=00, FE_n=1, PL_n=0, MAP_n=1, VECT_n=1. The sequencer therefore emits address 0.
- Reset mid-operation discards any pending push/pop/load in that cycle.

Test Plan:
1. RST=1 for 2 cycles with I=1, CC_n=0 -> ZERO_n=0, FE_n=1, CTR_ZERO=1, STK_EMPTY=1, ERR=0. After release with I=E -> S=00, ZERO_n=1.
2. I=C, D=3, then I=9 for 4 cycles:
   - RPCT cycles 1–3: S=11, counter 3→2→1→0.
   - RPCT cycle 4: S=00, CTR_ZERO=1.
3. I=1 with CCEN_n=0, CC_n=0 -> S=11, FE_n=0, PUP=1, depth 1. Then I=A with CC_n=1 -> S=00, FE_n=1, depth 1. Then I=A with CC_n=0 -> S=10, PUP=0, depth 0.
4. Five consecutive I=4 pushes -> STK_FULL after the 4th push, ERR=1 after the 5th, depth=4. Then I=0 -> ZERO_n=0, depth 0, ERR=0. Then I=B with PASS -> ERR=1 (underflow).
5. I=4 with D=2 and PASS, then I=F with CC_n=1 (CCEN_n=0):
   - TWB: S=10 with decrement twice (counter 2→1→0).
   - Then S=11 with FE_n=0, PUP=0, depth 0.
6. I=2 -> S=11, MAP_n=0, PL_n=1. I=6 with CC_n=1 and CCEN_n=0 -> S=00, VECT_n=0, PL_n=1.
